serial_word_receiver: RTL and testbench

Receive side of the team's MSB-first serial word link. Collects `WIDTH` bits from `ser_in` on qualified `bit_en` cycles after a `start` strobe and assembles them into a parallel word. Presents the word on `par_out` with a valid/ready handshake. It pairs with the parallel-load, MSB-shift-out transmit register in the datapath, whose shift-enable drives `bit_en`.

---
 rtl/serial_word_receiver_pkg.sv | 5 +
 rtl/ser_bit_counter.sv | 18 +
 rtl/serial_word_receiver.sv | 60 ++++++
 tb/tb_serial_word_receiver.sv | 118 +++++++++++
 4 files changed

// File: rtl/serial_word_receiver_pkg.sv
// serial_word_receiver_pkg: FSM encodings and default word length shared by the serial link blocks.
package serial_word_receiver_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_RECV = 1'b1} state_t;
    localparam int DEF_WIDTH = 16;
endpackage

// File: rtl/ser_bit_counter.sv
// ser_bit_counter: up-counter with sync clear and enable; o_tc flags that the next enable reaches LIMIT.
module ser_bit_counter #(
    parameter int LIMIT = 16,
    parameter int CW = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    logic [CW-1:0] r_cnt;
    // Clear together with enable counts the current bit, so a restart lands on 1.
    always_ff @(posedge clk or posedge rst)
        if (rst) r_cnt <= '0;
        else r_cnt <= i_clr ? CW'(i_en) : r_cnt + CW'(i_en);
    assign o_tc = r_cnt == CW'(LIMIT - 1);
endmodule

// File: rtl/serial_word_receiver.sv
// serial_word_receiver: assembles MSB-first serial bits into a word and hands it out with valid/ready.
module serial_word_receiver
    import serial_word_receiver_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_en,
    input  logic             ser_in,
    input  logic             out_ready,
    output logic [WIDTH-1:0] par_out,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun
);
    state_t r_state, w_next;
    logic [WIDTH-1:0] r_shreg, r_par, w_shift;
    logic r_valid, r_overrun, w_take, w_done, w_tc;
    assign w_shift = {r_shreg[WIDTH-2:0], ser_in};
    assign w_take  = bit_en & (start | r_state == ST_RECV);
    // A start always restarts the frame, so it can never complete one.
    assign w_done  = bit_en & ~start & r_state == ST_RECV & w_tc;
    ser_bit_counter #(.LIMIT(WIDTH)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .i_clr(start | w_done | r_state == ST_IDLE),
        .i_en (w_take & ~w_done),
        .o_tc (w_tc)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= ST_IDLE;
        else r_state <= w_next;
    always_comb begin
        w_next = r_state;
        if (start) w_next = ST_RECV;
        else if (w_done) w_next = ST_IDLE;
    end
    always_comb begin
        busy = r_state == ST_RECV;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_shreg   <= '0;
            r_par     <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_take) r_shreg <= w_shift;
            if (w_done & (~r_valid | out_ready)) begin
                r_par   <= w_shift;
                r_valid <= 1'b1;
            end else if (r_valid & out_ready) r_valid <= 1'b0;
            if (w_done & r_valid & ~out_ready) r_overrun <= 1'b1;
        end
    assign par_out   = r_par;
    assign out_valid = r_valid;
    assign overrun   = r_overrun;
endmodule

// File: tb/tb_serial_word_receiver.sv
// tb_serial_word_receiver: directed stimulus with immediate-assertion checks for serial_word_receiver.
module tb_serial_word_receiver;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, bit_en = 1'b0, ser_in = 1'b0, out_ready = 1'b0;
    logic [15:0] par_out;
    logic out_valid, busy, overrun;
    int total = 0, fails = 0;

    always #5 clk = ~clk;

    serial_word_receiver #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .bit_en(bit_en), .ser_in(ser_in),
        .out_ready(out_ready), .par_out(par_out), .out_valid(out_valid),
        .busy(busy), .overrun(overrun)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic s, input logic en, input logic b, input logic rdy);
        @(negedge clk);
        start = s; bit_en = en; ser_in = b; out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [15:0] w, input int n, input logic use_start,
                             input int gap, input logic rdy, input logic rdy_last);
        for (int i = 0; i < n; i++) begin
            step(use_start && i == 0, 1'b1, w[15-i], (i == n - 1) ? rdy_last : rdy);
            if (i != n - 1)
                for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, rdy);
        end
    endtask

    initial begin
        #2;
        chk("rst_par", par_out, 16'h0);
        chk("rst_valid", {15'b0, out_valid}, 16'h0);
        chk("rst_busy", {15'b0, busy}, 16'h0);
        chk("rst_ovr", {15'b0, overrun}, 16'h0);
        @(negedge clk); rst = 1'b0;

        send_bits(16'hA5C3, 16, 1'b1, 0, 1'b0, 1'b0);
        chk("a5c3_valid", {15'b0, out_valid}, 16'h1);
        chk("a5c3_par", par_out, 16'hA5C3);
        chk("a5c3_busy", {15'b0, busy}, 16'h0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("a5c3_hold_par", par_out, 16'hA5C3);
        chk("a5c3_hold_valid", {15'b0, out_valid}, 16'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("a5c3_consumed", {15'b0, out_valid}, 16'h0);

        send_bits(16'h8001, 16, 1'b1, 2, 1'b0, 1'b0);
        chk("8001_valid", {15'b0, out_valid}, 16'h1);
        chk("8001_par", par_out, 16'h8001);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("8001_cleared", {15'b0, out_valid}, 16'h0);
        chk("8001_par_kept", par_out, 16'h8001);

        send_bits(16'h1234, 16, 1'b1, 0, 1'b0, 1'b0);
        chk("1234_par", par_out, 16'h1234);
        chk("1234_ovr", {15'b0, overrun}, 16'h0);
        send_bits(16'hFFFF, 16, 1'b1, 0, 1'b0, 1'b0);
        chk("drop_par", par_out, 16'h1234);
        chk("drop_ovr", {15'b0, overrun}, 16'h1);
        chk("drop_valid", {15'b0, out_valid}, 16'h1);
        send_bits(16'hFFFF, 16, 1'b1, 0, 1'b0, 1'b1);
        chk("swap_par", par_out, 16'hFFFF);
        chk("swap_valid", {15'b0, out_valid}, 16'h1);
        chk("swap_ovr", {15'b0, overrun}, 16'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("swap_consumed", {15'b0, out_valid}, 16'h0);

        send_bits(16'hFFFF, 9, 1'b1, 0, 1'b0, 1'b0);
        chk("abort_busy", {15'b0, busy}, 16'h1);
        chk("abort_no_word", {15'b0, out_valid}, 16'h0);
        send_bits(16'h00FF, 16, 1'b1, 0, 1'b0, 1'b0);
        chk("abort_valid", {15'b0, out_valid}, 16'h1);
        chk("abort_par", par_out, 16'h00FF);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        send_bits(16'h1111, 7, 1'b1, 0, 1'b0, 1'b0);
        @(negedge clk); rst = 1'b1; #1;
        chk("mid_rst_par", par_out, 16'h0);
        chk("mid_rst_valid", {15'b0, out_valid}, 16'h0);
        chk("mid_rst_busy", {15'b0, busy}, 16'h0);
        chk("mid_rst_ovr", {15'b0, overrun}, 16'h0);
        @(negedge clk); rst = 1'b0;
        send_bits(16'hC0DE, 16, 1'b0, 0, 1'b0, 1'b0);
        chk("nostart_valid", {15'b0, out_valid}, 16'h0);
        chk("nostart_busy", {15'b0, busy}, 16'h0);
        send_bits(16'hC0DE, 16, 1'b1, 0, 1'b0, 1'b0);
        chk("c0de_valid", {15'b0, out_valid}, 16'h1);
        chk("c0de_par", par_out, 16'hC0DE);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        send_bits(16'hAAAA, 16, 1'b1, 0, 1'b1, 1'b1);
        chk("b2b_a_valid", {15'b0, out_valid}, 16'h1);
        chk("b2b_a_par", par_out, 16'hAAAA);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("b2b_a_one_cycle", {15'b0, out_valid}, 16'h0);
        chk("b2b_busy", {15'b0, busy}, 16'h1);
        send_bits(16'hAAAA, 15, 1'b0, 0, 1'b1, 1'b1);
        chk("b2b_b_valid", {15'b0, out_valid}, 16'h1);
        chk("b2b_b_par", par_out, 16'h5555);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("b2b_b_one_cycle", {15'b0, out_valid}, 16'h0);
        chk("b2b_ovr", {15'b0, overrun}, 16'h0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
